spi_cmd_arbiter: RTL
====================

SPI_CMD_ARBITER -- requirements
Module: spi_cmd_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16: max commands per grant before forced rotation when the other requester waits.
REQ-002 SHALL have parameter TIMEOUT, default 255: idle-cycle limit mid-packet, used only with SPI_ARB_TIMEOUT_EN.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports r0_valid/r1_valid  in  1  requester has a command.
REQ-006 SHALL have ports r0_cmd/r1_cmd  in  9  {mode, data[7:0]}, stable while valid.
REQ-007 SHALL have ports r0_last/r1_last  in  1  command ends the requester's packet.
REQ-008 SHALL have ports r0_ready/r1_ready  out  1  command consumed this cycle.
REQ-009 SHALL have port spi_valid  out  1  one-cycle command strobe to the SPI engine.
REQ-010 SHALL have ports spi_cmd  out  8 and spi_mode  out  1  command byte and mode bit.
REQ-011 SHALL have port spi_ready  in  1  SPI engine idle.
REQ-012 SHALL have port grant  out  2  one-hot current owner; 0 when idle.
REQ-013 SHALL have port timeout_err  out  1  one-cycle pulse on forced release (macro only; tied 0 otherwise).

Function
REQ-014 SHALL implement states IDLE, ISSUE, PULSE, HOLD.
REQ-015 IDLE: if any rX_valid, SHALL register grant next cycle and enter ISSUE; round-robin, the requester not granted last wins a tie.
REQ-016 ISSUE: rX_ready SHALL be combinational (state==ISSUE & grant[X] & rX_valid & spi_ready); on that handshake, cmd is captured and state goes to PULSE.
REQ-017 PULSE: spi_valid=1 for exactly this cycle with captured spi_cmd/spi_mode; next state HOLD.
REQ-018 HOLD: one cycle, spi_ready ignored (engine de-assertion latency); then ISSUE, or IDLE if packet ended.
REQ-019 Packet SHALL end when the handshaken command had rX_last=1, or burst count reaches MAX_BURST while the other requester's valid=1; on end, last-granted pointer updates, grant clears in IDLE.
REQ-020 Burst counter SHALL reset on each new grant, saturate at MAX_BURST, and not force rotation if the other requester is idle.
REQ-021 Granted requester dropping valid mid-packet SHALL keep grant (packet lock) in ISSUE.
REQ-022 Minimum command spacing SHALL be 3 cycles (ISSUE, PULSE, HOLD); latency valid->spi_valid from IDLE is 3 cycles with spi_ready=1.
REQ-023 spi_valid SHALL never assert unless spi_ready was 1 in the handshake cycle.
REQ-024 rX_ready SHALL never assert for the non-granted requester; at most one rX_ready per cycle.

Reset
REQ-025 rst SHALL asynchronously force IDLE, grant=0, spi_valid=0, spi_cmd=0, spi_mode=0, timeout_err=0, burst/timeout counters=0, pointer favouring r0.
REQ-026 Reset mid-packet SHALL drop any captured command without issuing it.

Configuration
REQ-027 With SPI_ARB_TIMEOUT_EN defined: in ISSUE, if granted rX_valid=0 for TIMEOUT consecutive cycles, grant SHALL be released, pointer rotated, timeout_err pulsed one cycle, state IDLE.
REQ-028 Without SPI_ARB_TIMEOUT_EN: no timeout counter, grant held indefinitely, timeout_err constant 0.

Verification
REQ-029 After reset, r0_valid=1 cmd=0x155 last=1, spi_ready=1 -> grant=01 next cycle, spi_valid pulse with spi_cmd=0x55, spi_mode=1 3 cycles after valid, then grant=00.
REQ-030 r0,r1 both valid with last=1 every command -> issued order r0,r1,r0,r1 (strict alternation).
REQ-031 r1 4-cmd packet (last on 4th) while r0 valid, MAX_BURST=16 -> all 4 r1 commands issued before any r0 command.
REQ-032 r0 20-cmd packet, r1 waiting, MAX_BURST=16 -> grant switches to r1 after 16th r0 command; r0 alone sends 20 without rotation.
REQ-033 spi_ready held 0 for 10 cycles in ISSUE -> no rX_ready, no spi_valid; first spi_valid 1 cycle after spi_ready returns to 1 handshake.
REQ-034 SPI_ARB_TIMEOUT_EN, TIMEOUT=8: r0 drops valid mid-packet -> timeout_err pulse after 8 cycles, grant=00; async rst during PULSE -> spi_valid=0 immediately.

Source files
------------

// File: rtl/spi_cmd_arbiter.sv
// Two-requester round-robin arbiter that hands single command bytes to an SPI engine.
// Define SPI_ARB_TIMEOUT_EN to release a grant whose owner stays idle mid-packet.
module spi_cmd_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r0_valid,
    input  logic [8:0] r0_cmd,
    input  logic       r0_last,
    output logic       r0_ready,
    input  logic       r1_valid,
    input  logic [8:0] r1_cmd,
    input  logic       r1_last,
    output logic       r1_ready,
    output logic       spi_valid,
    output logic [7:0] spi_cmd,
    output logic       spi_mode,
    input  logic       spi_ready,
    output logic [1:0] grant,
    output logic       timeout_err
);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, PULSE, HOLD} state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;       // 1 when r1 owned the most recent grant
    logic [BW-1:0] burst_q, burst_d, burst_inc;
    logic          end_q, end_d;
    logic [8:0]    cmd_q, cmd_d;
    logic          sel_valid, sel_last, oth_valid, handshake, tmo_fire;
    logic [8:0]    sel_cmd;

    assign sel_valid = grant_q[1] ? r1_valid : r0_valid;
    assign sel_last  = grant_q[1] ? r1_last  : r0_last;
    assign sel_cmd   = grant_q[1] ? r1_cmd   : r0_cmd;
    assign oth_valid = grant_q[1] ? r0_valid : r1_valid;

    assign handshake = (state_q == ISSUE) && sel_valid && spi_ready;
    assign r0_ready  = handshake && grant_q[0];
    assign r1_ready  = handshake && grant_q[1];
    assign burst_inc = (burst_q == BW'(MAX_BURST)) ? burst_q : burst_q + 1'b1;

    assign spi_valid = (state_q == PULSE);
    assign spi_cmd   = cmd_q[7:0];
    assign spi_mode  = cmd_q[8];
    assign grant     = grant_q;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_err_q;

    // Counts consecutive ISSUE cycles in which the owner has nothing to send.
    assign tmo_fire = (state_q == ISSUE) && !sel_valid && (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        tmo_d = '0;
        if ((state_q == ISSUE) && !sel_valid && !tmo_fire)
            tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_fire;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        end_d   = end_q;
        cmd_d   = cmd_q;
        case (state_q)
            IDLE: begin
                if (r0_valid || r1_valid) begin
                    state_d = ISSUE;
                    burst_d = '0;
                    grant_d = (r0_valid && (!r1_valid || last_q)) ? 2'b01 : 2'b10;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    cmd_d   = sel_cmd;
                    burst_d = burst_inc;
                    end_d   = sel_last || ((burst_inc == BW'(MAX_BURST)) && oth_valid);
                    state_d = PULSE;
                end else if (tmo_fire) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = grant_q[1];
                end
            end
            PULSE: state_d = HOLD;
            HOLD: begin
                // Engine needs a cycle to drop spi_ready, so it is not looked at here.
                if (end_q) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = grant_q[1];
                end else begin
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            burst_q <= '0;
            end_q   <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            end_q   <= end_d;
            cmd_q   <= cmd_d;
        end
    end
endmodule
